// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial IF/MEM arbiter for a shared 8-bit RAM (option: MEMCTRL_FAIR_ARB_EN enables round-robin arbitration)
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        IF_req_in,
  input  logic [31:0] IF_addr_in,
  output logic        IF_done_out,
  output logic [31:0] IF_inst_out,
  input  logic        MEM_req_in,
  input  logic        MEM_we_in,
  input  logic [1:0]  MEM_len_in,
  input  logic [31:0] MEM_addr_in,
  input  logic [31:0] MEM_data_in,
  output logic        MEM_done_out,
  output logic [31:0] MEM_data_out,
  output logic [31:0] ram_addr_out,
  output logic        ram_wr_out,
  output logic [7:0]  ram_data_out,
  input  logic [7:0]  ram_data_in
);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_cnt, r_n, w_len;
  logic        r_owner, w_grant, w_pick_mem, w_addr_act;
  logic [31:0] r_base, r_wdata, r_rdata;
  logic [1:0]  w_lane;
  assign w_grant = IF_req_in || MEM_req_in;
  assign w_len = (MEM_len_in == 2'b00) ? 3'd1 : (MEM_len_in == 2'b01) ? 3'd2 : 3'd4;
  assign w_lane = r_cnt[1:0] - 2'd1;
`ifdef MEMCTRL_FAIR_ARB_EN
  logic r_last;
  assign w_pick_mem = MEM_req_in && (!IF_req_in || !r_last);
  // remember who was granted last so contention alternates
  always_ff @(posedge clk_in)
    if (rst_in) r_last <= 1'b0;
    else if (r_state == IDLE && w_grant) r_last <= w_pick_mem;
`else
  assign w_pick_mem = MEM_req_in;
`endif
  // state register
  always_ff @(posedge clk_in)
    r_state <= rst_in ? IDLE : w_next;
  // next-state: grant only from IDLE, so a held req is not re-issued in DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !w_grant ? IDLE : (w_pick_mem && MEM_we_in) ? WRITE : READ;
      READ:    w_next = (r_cnt == r_n) ? DONE : READ;
      WRITE:   w_next = (r_cnt == r_n - 3'd1) ? DONE : WRITE;
      default: w_next = IDLE;
    endcase
  end
  // latch request on grant, step the byte counter, assemble read bytes
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cnt   <= '0;
      r_n     <= '0;
      r_owner <= 1'b0;
      r_base  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_cnt <= (r_state == READ || r_state == WRITE) ? r_cnt + 3'd1 : 3'd0;
      if (r_state == IDLE && w_grant) begin
        r_owner <= w_pick_mem;
        r_n     <= w_pick_mem ? w_len : 3'd4;
        r_base  <= w_pick_mem ? MEM_addr_in : IF_addr_in;
        r_wdata <= w_pick_mem ? MEM_data_in : 32'd0;
        r_rdata <= '0;
      end
      if (r_state == READ && r_cnt != 3'd0) r_rdata[{w_lane, 3'b000} +: 8] <= ram_data_in;
    end
  end
  // Moore outputs decoded from registered state; idle bus is all zeros
  always_comb begin
    w_addr_act   = (r_state == READ && r_cnt < r_n) || r_state == WRITE;
    ram_addr_out = w_addr_act ? r_base + {29'd0, r_cnt} : 32'd0;
    ram_wr_out   = r_state == WRITE;
    ram_data_out = (r_state == WRITE) ? r_wdata[{r_cnt[1:0], 3'b000} +: 8] : 8'd0;
    IF_done_out  = r_state == DONE && !r_owner;
    MEM_done_out = r_state == DONE && r_owner;
    IF_inst_out  = IF_done_out ? r_rdata : 32'd0;
    MEM_data_out = MEM_done_out ? r_rdata : 32'd0;
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a byte RAM model
module tb_mem_ctrl;
  logic        clk_in = 1'b0, rst_in = 1'b1;
  logic        IF_req_in = 1'b0, MEM_req_in = 1'b0, MEM_we_in = 1'b0;
  logic [31:0] IF_addr_in = '0, MEM_addr_in = '0, MEM_data_in = '0;
  logic [1:0]  MEM_len_in = '0;
  logic        IF_done_out, MEM_done_out, ram_wr_out;
  logic [31:0] IF_inst_out, MEM_data_out, ram_addr_out;
  logic [7:0]  ram_data_out, ram_data_in;
  logic [7:0]  mem [0:2047];
  logic        poke_en = 1'b0, mem_clr = 1'b0;
  logic [31:0] poke_a = '0;
  logic [7:0]  poke_d = '0;
  int          n_run = 0, n_fail = 0;
  logic        first_mem;
  int          c, pulses;
  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .IF_req_in(IF_req_in), .IF_addr_in(IF_addr_in), .IF_done_out(IF_done_out), .IF_inst_out(IF_inst_out),
    .MEM_req_in(MEM_req_in), .MEM_we_in(MEM_we_in), .MEM_len_in(MEM_len_in), .MEM_addr_in(MEM_addr_in),
    .MEM_data_in(MEM_data_in), .MEM_done_out(MEM_done_out), .MEM_data_out(MEM_data_out),
    .ram_addr_out(ram_addr_out), .ram_wr_out(ram_wr_out), .ram_data_out(ram_data_out), .ram_data_in(ram_data_in)
  );
  always #5 clk_in = ~clk_in;
  function automatic logic [10:0] idx(input logic [31:0] a);
    return {a[17], a[9:0]};
  endfunction
  always @(posedge clk_in) begin
    ram_data_in <= mem[idx(ram_addr_out)];
    if (mem_clr) for (int i = 0; i < 2048; i++) mem[i] <= 8'd0;
    if (poke_en) mem[idx(poke_a)] <= poke_d;
    if (ram_wr_out) mem[idx(ram_addr_out)] <= ram_data_out;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    poke_a = a;
    poke_d = d;
    poke_en = 1'b1;
    tick;
    poke_en = 1'b0;
  endtask
  task automatic wait_done(input logic m, input int maxc, output int cnt);
    cnt = 0;
    while (!(m ? MEM_done_out : IF_done_out) && cnt < maxc) begin
      tick;
      cnt++;
    end
    chk("done_seen", {31'd0, m ? MEM_done_out : IF_done_out}, 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
`ifdef MEMCTRL_FAIR_ARB_EN
    first_mem = 1'b0;
`else
    first_mem = 1'b1;
`endif
    mem_clr = 1'b1;
    tick;
    mem_clr = 1'b0;
    poke(32'h100, 8'h13);
    poke(32'h101, 8'h05);
    poke(32'h102, 8'h10);
    poke(32'h103, 8'h00);
    poke(32'hFFFFFFFF, 8'h34);
    poke(32'h0, 8'h12);
    tick;
    chk("rst_addr", ram_addr_out, 32'h0);
    chk("rst_flags", {28'd0, ram_wr_out, IF_done_out, MEM_done_out, 1'b0}, 32'h0);
    chk("rst_data", IF_inst_out | MEM_data_out | {24'd0, ram_data_out}, 32'h0);
    rst_in = 1'b0;
    IF_req_in = 1'b1;
    IF_addr_in = 32'h100;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("fetch_addr", ram_addr_out, 32'h100 + i);
    end
    tick;
    chk("fetch_early_done", {31'd0, IF_done_out}, 32'd0);
    tick;
    chk("fetch_done", {31'd0, IF_done_out}, 32'd1);
    chk("fetch_inst", IF_inst_out, 32'h00100513);
    IF_req_in = 1'b0;
    tick;
    chk("fetch_done_once", {31'd0, IF_done_out}, 32'd0);
    MEM_req_in = 1'b1;
    MEM_we_in = 1'b1;
    MEM_len_in = 2'b00;
    MEM_addr_in = 32'h30000;
    MEM_data_in = 32'hAABBCC41;
    tick;
    chk("sb_write", {ram_wr_out, 23'd0, ram_data_out}, {1'b1, 23'd0, 8'h41});
    chk("sb_addr", ram_addr_out, 32'h30000);
    tick;
    chk("sb_done", {30'd0, MEM_done_out, ram_wr_out}, 32'h2);
    MEM_req_in = 1'b0;
    MEM_we_in = 1'b0;
    tick;
    chk("sb_mem", {16'd0, mem[idx(32'h30001)], mem[idx(32'h30000)]}, 32'h41);
    MEM_req_in = 1'b1;
    MEM_len_in = 2'b01;
    MEM_addr_in = 32'hFFFFFFFF;
    tick;
    chk("lh_addr0", ram_addr_out, 32'hFFFFFFFF);
    tick;
    chk("lh_addr_wrap", ram_addr_out, 32'h0);
    tick;
    chk("lh_early_done", {31'd0, MEM_done_out}, 32'd0);
    tick;
    chk("lh_done", {31'd0, MEM_done_out}, 32'd1);
    chk("lh_data", MEM_data_out, 32'h00001234);
    MEM_req_in = 1'b0;
    tick;
    IF_req_in = 1'b1;
    IF_addr_in = 32'h100;
    MEM_req_in = 1'b1;
    MEM_len_in = 2'b00;
    MEM_addr_in = 32'h30000;
    tick;
    chk("arb_first_addr", ram_addr_out, first_mem ? 32'h30000 : 32'h100);
    wait_done(first_mem, 8, c);
    chk("arb_first_data", first_mem ? MEM_data_out : IF_inst_out, first_mem ? 32'h41 : 32'h00100513);
    if (first_mem) MEM_req_in = 1'b0;
    else IF_req_in = 1'b0;
    tick;
    chk("arb_gap", ram_addr_out, 32'h0);
    tick;
    chk("arb_second_addr", ram_addr_out, first_mem ? 32'h100 : 32'h30000);
    wait_done(!first_mem, 8, c);
    chk("arb_second_data", first_mem ? IF_inst_out : MEM_data_out, first_mem ? 32'h00100513 : 32'h41);
    IF_req_in = 1'b0;
    MEM_req_in = 1'b0;
    tick;
    MEM_req_in = 1'b1;
    MEM_we_in = 1'b1;
    MEM_len_in = 2'b10;
    MEM_addr_in = 32'h200;
    MEM_data_in = 32'hDDCCBBAA;
    tick;
    chk("sw_byte0", {24'd0, ram_data_out}, 32'hAA);
    tick;
    tick;
    chk("sw_byte2", {ram_addr_out[23:0], ram_data_out}, 32'h000202CC);
    rst_in = 1'b1;
    MEM_req_in = 1'b0;
    tick;
    chk("rst_mid_addr", ram_addr_out, 32'h0);
    chk("rst_mid_flags", {29'd0, ram_wr_out, MEM_done_out, IF_done_out}, 32'h0);
    chk("rst_mid_data", {24'd0, ram_data_out} | MEM_data_out, 32'h0);
    rst_in = 1'b0;
    tick;
    chk("rst_no_done", {31'd0, MEM_done_out}, 32'd0);
    chk("rst_partial", {mem[idx(32'h203)], mem[idx(32'h202)], mem[idx(32'h201)], mem[idx(32'h200)]}, 32'h00CCBBAA);
    MEM_req_in = 1'b1;
    wait_done(1'b1, 10, c);
    chk("sw_latency", c, 32'd5);
    MEM_req_in = 1'b0;
    MEM_we_in = 1'b0;
    tick;
    chk("sw_mem", {mem[idx(32'h203)], mem[idx(32'h202)], mem[idx(32'h201)], mem[idx(32'h200)]}, 32'hDDCCBBAA);
    IF_req_in = 1'b1;
    IF_addr_in = 32'h100;
    pulses = 0;
    for (int i = 1; i <= 13; i++) begin
      tick;
      pulses += int'(IF_done_out);
      if (i == 7) chk("held_idle_addr", ram_addr_out, 32'h0);
      if (i == 8) chk("held_regrant_addr", ram_addr_out, 32'h100);
    end
    IF_req_in = 1'b0;
    chk("held_pulses", pulses, 32'd2);
    tick;
    tick;
    chk("held_quiet", {31'd0, IF_done_out}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
